// File: rtl/capture_fifo_stage.sv
// Burst-capture stage: a small control FSM admits burst_len words per start request into a
// DEPTH-entry FIFO whose drain side runs independently of the FSM.
module capture_fifo_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               burst_len,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StActive = 2'b01,
    StDone   = 2'b10
  } state_e;

  state_e            state_q;
  logic [7:0]        rem_q;
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              push, pop;

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop at full frees the slot for a same-cycle push.
  assign in_ready  = (state_q == StActive) && ((cnt_q < FullCnt) || pop);
  assign push      = in_valid & in_ready;

  assign out_data  = mem_q[rptr_q];
  assign count     = cnt_q;
  assign busy      = (state_q == StActive);
  assign done      = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (burst_len != 8'd0) begin
              state_q <= StActive;
              rem_q   <= burst_len;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StActive: begin
          if (push) begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_q <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        // Illegal encoding falls back to idle.
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
    end
  end

  // Storage carries no reset; out_data is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data;
    end
  end

endmodule

// File: doc/capture_fifo_stage.md
CAPTURE_FIFO_STAGE -- requirements
Module: capture_fifo_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 Port clk SHALL be input, 1 bit, sole clock; all flops rising-edge.
REQ-004 Port rst_n SHALL be input, 1 bit, reset; asynchronous, active-low.
REQ-005 Port start SHALL be input, 1 bit, single-cycle request to open a capture burst.
REQ-006 Port burst_len SHALL be input, 8 bits, words per burst; sampled when start is accepted.
REQ-007 Port in_valid SHALL be input, 1 bit, upstream word available.
REQ-008 Port in_data SHALL be input, WIDTH bits, upstream word.
REQ-009 Port in_ready SHALL be output, 1 bit, block accepts in_data this cycle.
REQ-010 Port out_valid SHALL be output, 1 bit, FIFO head word valid.
REQ-011 Port out_data SHALL be output, WIDTH bits, FIFO head word.
REQ-012 Port out_ready SHALL be input, 1 bit, downstream takes head word.
REQ-013 Port count SHALL be output, $clog2(DEPTH)+1 bits, current FIFO occupancy.
REQ-014 Port busy SHALL be output, 1 bit, high while state is ACTIVE.
REQ-015 Port done SHALL be output, 1 bit, one-cycle pulse at burst completion.

Function
REQ-016 The control FSM SHALL have exactly three states: IDLE, ACTIVE, DONE, encoded 2'b00, 2'b01, 2'b10; 2'b11 SHALL recover to IDLE on the next edge.
REQ-017 IDLE -> ACTIVE SHALL occur on start=1 with burst_len!=0; burst_len is latched into a remaining-word counter.
REQ-018 In IDLE, start=1 with burst_len=0 SHALL go directly to DONE; no word is accepted.
REQ-019 The FSM SHALL ignore start in ACTIVE and DONE.
REQ-020 in_ready SHALL equal (state==ACTIVE) and (count<DEPTH or pop this cycle); combinational, no registered lag.
REQ-021 A word SHALL be written when in_valid and in_ready are both 1; the remaining-word counter decrements by 1.
REQ-022 ACTIVE -> DONE SHALL occur on the edge where the last word (remaining==1) is written.
REQ-023 DONE -> IDLE SHALL occur unconditionally after one cycle; done=1 only while in DONE.
REQ-024 out_valid SHALL equal (count!=0); out_data SHALL present the oldest stored word with zero-cycle read latency.
REQ-025 A pop SHALL occur when out_valid and out_ready are both 1; the read pointer advances by 1.
REQ-026 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-027 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH (full: pop frees the slot for the same-cycle push) and count=0 (no push-through; a word written at count=0 appears on out_data the next cycle).
REQ-028 count SHALL never exceed DEPTH nor underflow; out_ready with count=0 SHALL have no effect.
REQ-029 The FIFO drain side SHALL operate in all FSM states, so stored words remain poppable after DONE.

Reset
REQ-030 While rst_n=0: state=IDLE, pointers=0, count=0, remaining counter=0, out_valid=0, in_ready=0, busy=0, done=0.
REQ-031 FIFO storage SHALL NOT require reset; out_data is don't-care while out_valid=0.
REQ-032 Reset asserted mid-burst SHALL discard all stored words and the burst; no done pulse is generated.

Verification
REQ-033 Reset, then start with burst_len=3, in_valid held high, out_ready=1, data 0x11,0x22,0x33 -> busy 3 cycles, done pulses once in the cycle after 0x33 is accepted, out_data sequence is 0x11,0x22,0x33.
REQ-034 DEPTH=4, out_ready=0, burst_len=6 -> 4 words accepted, count=4, in_ready=0; raise out_ready -> remaining 2 accepted, then done; all 6 words output in order.
REQ-035 At count=4 with in_valid=1 and out_ready=1 for 8 cycles -> count stays 4 and pointers wrap twice with no data loss or duplication.
REQ-036 start with burst_len=0 -> done pulses on the next cycle, in_ready never asserts, count stays 0.
REQ-037 rst_n driven low after 2 of 5 words with count=2 -> out_valid=0 and count=0 immediately; after release, state=IDLE and done never pulses.
REQ-038 start pulsed again during ACTIVE with a different burst_len -> ignored; the burst completes with the original length.
